// File: rtl/pcla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Provides the derived group count and pipeline depth, plus a legality
// predicate used by the top level to reject non-divisible geometries.
package pcla_pkg;

  // Number of GS-bit lookahead groups in an N-bit operand.
  function automatic int unsigned calc_ng(input int unsigned n, input int unsigned gs);
    return n / gs;
  endfunction

  // Pipeline depth, which is also the latency in cycles.
  function automatic int unsigned calc_lat(input int unsigned n, input int unsigned gs,
                                           input int unsigned gps);
    return (n / gs) / gps;
  endfunction

  // True when N splits into whole groups and the groups into whole stages.
  function automatic bit params_ok(input int unsigned n, input int unsigned gs,
                                   input int unsigned gps);
    if (gs == 0 || gps == 0 || n == 0) return 1'b0;
    if ((n % gs) != 0) return 1'b0;
    if (((n / gs) % gps) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/pcla_group_stage.sv
// Combinational slice of the adder: GPS consecutive GS-bit lookahead groups.
// Each group forms bit propagate/generate, a local sum assuming zero carry-in,
// group P/G, and then increments the local sum with the incoming group carry.
// Ports:
//   a, b  [GS*GPS:1]  operand slices
//   cin               carry into the lowest group of the slice
//   sum   [GS*GPS:1]  sum slice
//   cout              carry out of the highest group of the slice
module pcla_group_stage #(
  parameter int unsigned GS  = 8,
  parameter int unsigned GPS = 1
) (
  input  logic [GS*GPS:1] a,
  input  logic [GS*GPS:1] b,
  input  logic            cin,
  output logic [GS*GPS:1] sum,
  output logic            cout
);

  localparam int unsigned W = GS * GPS;

  logic [W:1]   p;
  logic [W:1]   g;
  logic [GPS:0] gc;    // carries between groups; gc[0] is the slice carry-in
  logic         lc;    // running in-group carry assuming group carry-in = 0
  logic         pp;    // running in-group propagate (prefix AND of p)
  int unsigned  idx;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gc    = '0;
    gc[0] = cin;
    sum   = '0;
    lc    = 1'b0;
    pp    = 1'b1;
    idx   = 0;
    for (int k = 0; k < GPS; k++) begin
      lc = 1'b0;
      pp = 1'b1;
      for (int i = 1; i <= GS; i++) begin
        idx = k * GS + i;
        // Carry into this bit = local carry, or the group carry rippling through
        // every lower bit of the group (the carry-increment term).
        sum[idx] = p[idx] ^ (lc | (pp & gc[k]));
        lc       = g[idx] | (p[idx] & lc);
        pp       = pp & p[idx];
      end
      // Group generate is lc, group propagate is pp.
      gc[k+1] = lc | (pp & gc[k]);
    end
  end

  assign cout = gc[GPS];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead / carry-increment adder with valid/ready streaming.
// {cout,sum} = a + b + cin. The add is cut into LAT = (N/GS)/GPS stages; each
// stage resolves GPS groups from the carry registered by the previous stage and
// forwards its finished sum bits, the operands and its carry.
// Optional feature: define PCLA_OVERFLOW_EN to add the registered signed
// overflow output ovf.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake
//   a, b [N:1], cin      operands and carry in
//   out_valid/out_ready  result handshake
//   sum [N:1], cout      result
//   ovf                  signed overflow (PCLA_OVERFLOW_EN only)
module pipelined_cla_adder
  import pcla_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned GS  = 8,
  parameter int unsigned GPS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:1] a,
  input  logic [N:1] b,
  input  logic       cin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:1] sum,
  output logic       cout
`ifdef PCLA_OVERFLOW_EN
  ,
  output logic       ovf
`endif
);

  localparam int unsigned NG  = calc_ng(N, GS);
  localparam int unsigned LAT = calc_lat(N, GS, GPS);
  localparam int unsigned W   = GS * GPS;

  if (!params_ok(N, GS, GPS) || (LAT * GPS != NG)) begin : g_bad_params
    $fatal(1, "pipelined_cla_adder: N must be a multiple of GS and N/GS of GPS");
  end

  logic [LAT-1:0] v;       // stage holds a beat
  logic [LAT-1:0] adv;     // stage hands its beat on this cycle
  logic [LAT-1:0] load;    // stage register may capture this cycle
  logic [LAT-1:0] cin_s;   // carry entering each stage
  logic [N:1]     opa  [LAT];
  logic [N:1]     opb  [LAT];
  logic [N:1]     psum [LAT];  // sum bits finished by earlier stages

  assign cin_s[0] = cin;
  assign opa[0]   = a;
  assign opb[0]   = b;
  assign psum[0]  = '0;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    logic         v_q;
    logic         v_up;
    logic [W:1]   grp_sum;
    logic         grp_cout;
    logic [N:1]   sum_d;

    pcla_group_stage #(
      .GS  (GS),
      .GPS (GPS)
    ) u_grp (
      .a    (opa[s][s*W+1 +: W]),
      .b    (opb[s][s*W+1 +: W]),
      .cin  (cin_s[s]),
      .sum  (grp_sum),
      .cout (grp_cout)
    );

    always_comb begin
      sum_d               = psum[s];
      sum_d[s*W+1 +: W]   = grp_sum;
    end

    if (s == 0) begin : g_up_in
      assign v_up = in_valid;
    end else begin : g_up_stage
      assign v_up = v[s-1];
    end

    if (s == LAT - 1) begin : g_adv_last
      assign adv[s] = v_q & out_ready;
    end else begin : g_adv_mid
      assign adv[s] = v_q & (~v[s+1] | adv[s+1]);
    end

    // An empty stage always loads, so bubbles collapse.
    assign v[s]    = v_q;
    assign load[s] = ~v_q | adv[s];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (load[s]) begin
        v_q <= v_up;
      end
    end

    if (s < LAT - 1) begin : g_regs_mid
      logic [N:1] a_q;
      logic [N:1] b_q;
      logic [N:1] sum_q;
      logic       c_q;

      // Data only moves with a real beat so idle stages keep their contents.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
        end else if (load[s] && v_up) begin
          a_q   <= opa[s];
          b_q   <= opb[s];
          sum_q <= sum_d;
          c_q   <= grp_cout;
        end
      end

      assign opa[s+1]   = a_q;
      assign opb[s+1]   = b_q;
      assign psum[s+1]  = sum_q;
      assign cin_s[s+1] = c_q;
    end else begin : g_regs_last
`ifdef PCLA_OVERFLOW_EN
      logic ovf_d;
      // Carry into the MSB recovered from the MSB sum bit, xor carry out.
      assign ovf_d = grp_cout ^ (opa[s][N] ^ opb[s][N] ^ sum_d[N]);
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum  <= '0;
          cout <= 1'b0;
`ifdef PCLA_OVERFLOW_EN
          ovf  <= 1'b0;
`endif
        end else if (load[s] && v_up) begin
          sum  <= sum_d;
          cout <= grp_cout;
`ifdef PCLA_OVERFLOW_EN
          ovf  <= ovf_d;
`endif
        end
      end
    end
  end

  // Combinational from out_ready through the whole adv chain.
  assign in_ready  = load[0];
  assign out_valid = v[LAT-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (N=32, GS=8, GPS=1, LAT=4).
// Expected results are queued at acceptance and compared at emission.
module tb_pipelined_cla_adder;

  localparam int unsigned N   = 32;
  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N:1]   a;
  logic [N:1]   b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N:1]   sum;
  logic         cout;
`ifdef PCLA_OVERFLOW_EN
  logic         ovf;
`endif

  pipelined_cla_adder #(
    .N   (32),
    .GS  (8),
    .GPS (1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PCLA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          accepted = 0;
  int          emitted  = 0;
  int          last_lat = 0;
  logic        last_ready = 1'b0;
  logic [33:0] last_res = '0;     // {ovf, cout, sum}
  logic        hold_prev = 1'b0;
  logic [32:0] prev_res = '0;
  logic [33:0] exp_q [$];
  int          acc_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci);
    logic [32:0] r;
    longint      s;
    logic        o;
    r = {1'b0, av} + {1'b0, bv} + {32'd0, ci};
    s = longint'($signed(av)) + longint'($signed(bv)) + longint'(ci);
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {o, r};
  endfunction

  // One clock cycle: drive inputs, resolve both handshakes, then clock.
  task automatic step(input logic iv, input logic orr, input logic [31:0] av,
                      input logic [31:0] bv, input logic ci);
    logic [33:0] e;
    int          ac;
    in_valid  = iv;
    out_ready = orr;
    a         = av;
    b         = bv;
    cin       = ci;
    #1;
    if (hold_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'({cout, sum}), 64'(prev_res));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        check("result", 64'({cout, sum}), 64'(e[32:0]));
`ifdef PCLA_OVERFLOW_EN
        check("ovf", 64'(ovf), 64'(e[33]));
        last_res = {ovf, cout, sum};
`else
        last_res = {1'b0, cout, sum};
`endif
        last_lat = cyc - ac;
        emitted++;
      end
    end
    if (iv && in_ready) begin
      exp_q.push_back(model(av, bv, ci));
      acc_q.push_back(cyc);
      accepted++;
    end
    last_ready = in_ready;
    hold_prev  = out_valid && !out_ready;
    prev_res   = {cout, sum};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1'b0, 1'b1, '0, '0, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc0;
    int em0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'({cout, sum}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed: carry across a group boundary, latency.
    step(1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    drain();
    check("t1_sum", 64'(last_res[32:0]), 64'h0_0000_0100);
    check("t1_latency", 64'(last_lat), 64'(LAT));

    // Wrap-around through every group.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    drain();
    check("t2_wrap", 64'(last_res[32:0]), 64'h1_0000_0000);

    // Signed overflow case.
    step(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    check("t2_ovf_sum", 64'(last_res[32:0]), 64'h0_8000_0000);
`ifdef PCLA_OVERFLOW_EN
    check("t2_ovf_flag", 64'(last_res[33]), 64'd1);
`endif

    // Streaming at full throughput.
    acc0 = accepted;
    em0  = emitted;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    check("t3_accepted", 64'(accepted - acc0), 64'd100);
    check("t3_emitted", 64'(emitted - em0), 64'(100 - LAT));
    drain();

    // Fill with the consumer stalled, then release.
    acc0 = accepted;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    check("t4_fill_count", 64'(accepted - acc0), 64'(LAT));
    check("t4_full_ready", 64'(last_ready), 64'd0);
    em0 = emitted;
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b1, '0, '0, 1'b0);
    check("t4_drain_b2b", 64'(emitted - em0), 64'(LAT));
    check("t4_empty", 64'(exp_q.size()), 64'd0);

    // Random handshake toggling.
    acc0 = accepted;
    for (int i = 0; i < 20000 && (accepted - acc0) < 1000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
           1'($urandom_range(0, 1)));
    check("t5_accepted", 64'(accepted - acc0), 64'd1000);
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom(), $urandom(), 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_sum", 64'({cout, sum}), 64'd0);
    exp_q.delete();
    acc_q.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_ready_after_rst", 64'(in_ready), 64'd1);
    step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0);
    drain();
    check("t6_sum", 64'(last_res[32:0]), 64'd12);
    check("t6_latency", 64'(last_lat), 64'(LAT));
    em0 = emitted;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, '0, 1'b0);
    check("t6_no_stale", 64'(emitted - em0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
